fetch_redirect_unit: RTL and testbench

//  Consumer side of the pipeline hazard-control interface. Owns the PC register, the

---
 rtl/fetch_redirect_unit.sv | 86 ++++++++
 tb/tb_fetch_redirect_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_unit.sv
// PC register, next-PC select, IF/ID register and ID/EX control register, plus saturating stall/bubble/redirect counters.
// Latency: 1 cycle (a redirect appears on imem_addr the cycle after PC_write=1); no backpressure, the hazard unit's enables gate every register.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 16,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PC_write,
    input  logic              IF_write,
    input  logic              bubble,
    input  logic [1:0]        addrSel,
    input  logic [31:0]       jump_target,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       imem_rdata,
    input  logic [CTRL_W-1:0] id_ctrl_in,
    output logic [31:0]       imem_addr,
    output logic [31:0]       pc,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc4,
    output logic              if_id_valid,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic              sel_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  redirect_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        redirect;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign redirect  = PC_write && (addrSel == 2'b01 || addrSel == 2'b10);

    always_comb begin
        next_pc = pc_plus4;
        case (addrSel)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = {jump_target[31:2], 2'b00};
            2'b10:   next_pc = {branch_target[31:2], 2'b00};
            default: next_pc = pc;  // illegal select holds PC and raises sel_err
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            if_id_instr  <= 32'h0;
            if_id_pc4    <= 32'h0;
            if_id_valid  <= 1'b0;
            id_ex_ctrl   <= '0;
            sel_err      <= 1'b0;
            stall_cnt    <= '0;
            bubble_cnt   <= '0;
            redirect_cnt <= '0;
        end else begin
            if (PC_write) begin
                pc <= next_pc;
            end
            if (IF_write) begin
                if_id_instr <= imem_rdata;
                if_id_pc4   <= pc_plus4;
                if_id_valid <= 1'b1;
            end
            id_ex_ctrl <= bubble ? '0 : id_ctrl_in;
            sel_err    <= PC_write && (addrSel == 2'b11);
            // Counters stick at all-ones rather than wrapping.
            if (!PC_write && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (bubble && bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
            if (redirect && redirect_cnt != CNT_MAX) begin
                redirect_cnt <= redirect_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed vector table, hand-written saturation/reset sequence, random run against a reference model.
module tb_fetch_redirect_unit;

    localparam int CW   = 16;
    localparam int NW   = 4;
    localparam int MAXC = 15;
    localparam int NV   = 20;

    logic          clk = 1'b0;
    logic          reset, PC_write, IF_write, bubble;
    logic [1:0]    addrSel;
    logic [31:0]   jump_target, branch_target, imem_rdata;
    logic [CW-1:0] id_ctrl_in;
    logic [31:0]   imem_addr, pc, if_id_instr, if_id_pc4;
    logic          if_id_valid, sel_err;
    logic [CW-1:0] id_ex_ctrl;
    logic [NW-1:0] stall_cnt, bubble_cnt, redirect_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F13};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_redirect_unit #(.RESET_PC(32'h0), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset), .PC_write(PC_write), .IF_write(IF_write),
        .bubble(bubble), .addrSel(addrSel), .jump_target(jump_target),
        .branch_target(branch_target), .imem_rdata(imem_rdata), .id_ctrl_in(id_ctrl_in),
        .imem_addr(imem_addr), .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .id_ex_ctrl(id_ex_ctrl), .sel_err(sel_err),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .redirect_cnt(redirect_cnt)
    );

    // Reference model state: what the pipeline registers should hold after each edge.
    logic [31:0]   m_pc, m_pc4, m_instr;
    logic          m_valid, m_err;
    logic [CW-1:0] m_ctrl;
    int            m_st, m_bu, m_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] target;
        if (reset) begin
            m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
            m_ctrl = '0; m_err = 1'b0; m_st = 0; m_bu = 0; m_rd = 0;
        end else begin
            if (addrSel == 2'd0)      target = m_pc + 32'd4;
            else if (addrSel == 2'd1) target = jump_target & 32'hFFFF_FFFC;
            else if (addrSel == 2'd2) target = branch_target & 32'hFFFF_FFFC;
            else                      target = m_pc;
            if (IF_write) begin
                m_instr = mem_word(m_pc);
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
            end
            m_err  = PC_write && addrSel == 2'd3;
            m_ctrl = bubble ? '0 : id_ctrl_in;
            if (!PC_write) m_st = (m_st < MAXC) ? m_st + 1 : MAXC;
            if (bubble)    m_bu = (m_bu < MAXC) ? m_bu + 1 : MAXC;
            if (PC_write && (addrSel == 2'd1 || addrSel == 2'd2)) m_rd = (m_rd < MAXC) ? m_rd + 1 : MAXC;
            if (PC_write) m_pc = target;
        end
    endtask

    task automatic drive(input logic r, input logic pw, input logic iw, input logic b,
                         input logic [1:0] s, input logic [31:0] jt, input logic [31:0] bt,
                         input logic [CW-1:0] ci);
        reset = r; PC_write = pw; IF_write = iw; bubble = b; addrSel = s;
        jump_target = jt; branch_target = bt; id_ctrl_in = ci;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},        pc,                    m_pc);
        chk({tag, ".imem_addr"}, imem_addr,             m_pc);
        chk({tag, ".instr"},     if_id_instr,           m_instr);
        chk({tag, ".pc4"},       if_id_pc4,             m_pc4);
        chk({tag, ".valid"},     {31'd0, if_id_valid},  {31'd0, m_valid});
        chk({tag, ".ctrl"},      {16'd0, id_ex_ctrl},   {16'd0, m_ctrl});
        chk({tag, ".sel_err"},   {31'd0, sel_err},      {31'd0, m_err});
        chk({tag, ".stall"},     {28'd0, stall_cnt},    m_st);
        chk({tag, ".bubble"},    {28'd0, bubble_cnt},   m_bu);
        chk({tag, ".redir"},     {28'd0, redirect_cnt}, m_rd);
    endtask

    typedef struct {
        logic          rst, pw, iw, bub;
        logic [1:0]    sel;
        logic [31:0]   jt, bt;
        logic [CW-1:0] ci;
        logic [31:0]   e_pc, e_pc4;
        logic          e_v;
        logic [CW-1:0] e_ctrl;
        logic          e_err;
        logic [NW-1:0] e_st, e_bu, e_rd;
    } vec_t;

    vec_t vt [NV];

    initial begin
        // rst pw iw bub sel  jt            bt            ci         pc            pc4        v  ctrl     err st bu rd
        vt[0]  = '{1, 0, 0, 1, 0, 32'h0,        32'h0,        16'h1234, 32'h0,        32'h0,     0, 16'h0,    0, 0, 0, 0};
        vt[1]  = '{1, 0, 0, 1, 0, 32'h0,        32'h0,        16'h1234, 32'h0,        32'h0,     0, 16'h0,    0, 0, 0, 0};
        vt[2]  = '{1, 1, 1, 1, 1, 32'h700,      32'h0,        16'h1234, 32'h0,        32'h0,     0, 16'h0,    0, 0, 0, 0};
        vt[3]  = '{0, 1, 1, 0, 0, 32'h0,        32'h0,        16'h1111, 32'h4,        32'h4,     1, 16'h1111, 0, 0, 0, 0};
        vt[4]  = '{0, 1, 1, 0, 0, 32'h0,        32'h0,        16'h2222, 32'h8,        32'h8,     1, 16'h2222, 0, 0, 0, 0};
        vt[5]  = '{0, 0, 0, 1, 0, 32'h0,        32'h0,        16'h3333, 32'h8,        32'h8,     1, 16'h0,    0, 1, 1, 0};
        vt[6]  = '{0, 1, 1, 0, 0, 32'h0,        32'h0,        16'h4444, 32'hC,        32'hC,     1, 16'h4444, 0, 1, 1, 0};
        vt[7]  = '{0, 1, 1, 0, 0, 32'h0,        32'h0,        16'h5555, 32'h10,       32'h10,    1, 16'h5555, 0, 1, 1, 0};
        vt[8]  = '{0, 1, 0, 0, 1, 32'h103,      32'h0,        16'h6666, 32'h100,      32'h10,    1, 16'h6666, 0, 1, 1, 1};
        vt[9]  = '{0, 1, 1, 0, 0, 32'h0,        32'h0,        16'h7777, 32'h104,      32'h104,   1, 16'h7777, 0, 1, 1, 1};
        vt[10] = '{0, 1, 1, 1, 2, 32'h0,        32'h40,       16'hABCD, 32'h40,       32'h108,   1, 16'h0,    0, 1, 2, 2};
        vt[11] = '{0, 1, 1, 0, 0, 32'h0,        32'h0,        16'h8888, 32'h44,       32'h44,    1, 16'h8888, 0, 1, 2, 2};
        vt[12] = '{0, 1, 0, 0, 3, 32'h500,      32'h600,      16'h9999, 32'h44,       32'h44,    1, 16'h9999, 1, 1, 2, 2};
        vt[13] = '{0, 0, 0, 0, 3, 32'h500,      32'h600,      16'hAAAA, 32'h44,       32'h44,    1, 16'hAAAA, 0, 2, 2, 2};
        vt[14] = '{0, 1, 1, 0, 0, 32'h0,        32'h0,        16'hBBBB, 32'h48,       32'h48,    1, 16'hBBBB, 0, 2, 2, 2};
        vt[15] = '{0, 1, 1, 1, 1, 32'hFFFFFFFE, 32'h0,        16'hCCCC, 32'hFFFFFFFC, 32'h4C,    1, 16'h0,    0, 2, 3, 3};
        vt[16] = '{0, 1, 1, 0, 0, 32'h0,        32'h0,        16'hDDDD, 32'h0,        32'h0,     1, 16'hDDDD, 0, 2, 3, 3};
        vt[17] = '{0, 0, 1, 0, 1, 32'h800,      32'h0,        16'hEEEE, 32'h0,        32'h4,     1, 16'hEEEE, 0, 3, 3, 3};
        vt[18] = '{0, 1, 0, 0, 2, 32'h0,        32'h203,      16'h0F0F, 32'h200,      32'h4,     1, 16'h0F0F, 0, 3, 3, 4};
        vt[19] = '{1, 1, 1, 0, 0, 32'h0,        32'h0,        16'h5A5A, 32'h0,        32'h0,     0, 16'h0,    0, 0, 0, 0};

        reset = 1'b1; PC_write = 1'b0; IF_write = 1'b0; bubble = 1'b0; addrSel = 2'b00;
        jump_target = '0; branch_target = '0; id_ctrl_in = '0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(vt[i].rst, vt[i].pw, vt[i].iw, vt[i].bub, vt[i].sel, vt[i].jt, vt[i].bt, vt[i].ci);
            chk({t, ".pc"},     pc,                    vt[i].e_pc);
            chk({t, ".pc4"},    if_id_pc4,             vt[i].e_pc4);
            chk({t, ".valid"},  {31'd0, if_id_valid},  {31'd0, vt[i].e_v});
            chk({t, ".instr"},  if_id_instr,           vt[i].e_v ? mem_word(vt[i].e_pc4 - 32'd4) : 32'h0);
            chk({t, ".ctrl"},   {16'd0, id_ex_ctrl},   {16'd0, vt[i].e_ctrl});
            chk({t, ".sel_err"}, {31'd0, sel_err},     {31'd0, vt[i].e_err});
            chk({t, ".stall"},  {28'd0, stall_cnt},    {28'd0, vt[i].e_st});
            chk({t, ".bubble"}, {28'd0, bubble_cnt},   {28'd0, vt[i].e_bu});
            chk({t, ".redir"},  {28'd0, redirect_cnt}, {28'd0, vt[i].e_rd});
        end

        // Long stall with bubbles: both counters must stop at all-ones.
        for (int i = 0; i < 15; i++) drive(0, 0, 0, 1, 2'b01, 32'h300, 32'h0, 16'h7E7E);
        chk("sat.stall15",  {28'd0, stall_cnt},  32'd15);
        chk("sat.bubble15", {28'd0, bubble_cnt}, 32'd15);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 2'b00, 32'h0, 32'h0, 16'h7E7E);
        chk("sat.stall_hold",  {28'd0, stall_cnt},  32'd15);
        chk("sat.bubble_hold", {28'd0, bubble_cnt}, 32'd15);
        chk("sat.pc_hold",     pc,                  32'h0);
        chk("sat.redir",       {28'd0, redirect_cnt}, 32'd0);

        // Reset asserted in the middle of the stall.
        drive(1, 0, 0, 1, 2'b11, 32'h0, 32'h0, 16'hFFFF);
        chk("rst_mid.pc",    pc,                   32'h0);
        chk("rst_mid.stall", {28'd0, stall_cnt},   32'd0);
        chk("rst_mid.bub",   {28'd0, bubble_cnt},  32'd0);
        chk("rst_mid.valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_mid.ctrl",  {16'd0, id_ex_ctrl},  32'd0);
        chk("rst_mid.err",   {31'd0, sel_err},     32'd0);
        drive(0, 1, 1, 0, 2'b00, 32'h0, 32'h0, 16'h0101);
        chk("post_rst.pc",    pc,          32'h4);
        chk("post_rst.instr", if_id_instr, mem_word(32'h0));
        chk("post_rst.pc4",   if_id_pc4,   32'h4);
        check_model("post_rst");

        for (int n = 0; n < 400; n++) begin
            logic [1:0] s;
            s = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, s, $urandom, $urandom, CW'($urandom));
            check_model($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
